mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the pipeline's two memory requesters: port 0 is the data port used by the memory-access stage, port 1 is the instruction-fetch port.
- Holds a word-organised RAM and arbitrates between the two ports round-robin.
- Serves one transaction at a time with a req/ack handshake and a configurable number of wait states.
- Decodes func_3 for byte, half-word and word loads and stores, with sign or zero extension on loads.

Parameters:
- ADDR_WIDTH, 10: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: wait states between grant and ack; legal range 0..15.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_req_0  input  1  data-port request; held high until o_ack_0.
- i_we_0  input  1  data-port write: 1 = store, 0 = load.
- i_addr_0  input  32  data-port byte address.
- i_wdata_0  input  32  store data; the low byte or half-word is used for SB/SH.
- i_func_3_0  input  3  RV32I load/store func_3.
- o_ack_0  output  1  one-cycle completion pulse for port 0.
- o_rdata_0  output  32  load result; valid while o_ack_0 is high.
- o_err_0  output  1  misaligned or illegal access; valid while o_ack_0 is high.
- i_req_1  input  1  fetch request; held high until o_ack_1.
- i_addr_1  input  32  fetch byte address.
- o_ack_1  output  1  one-cycle completion pulse for port 1.
- o_rdata_1  output  32  instruction word; valid while o_ack_1 is high.
- o_busy  output  1  high in the WAIT and RESP states.

Behaviour:
- Reset:
  - Asynchronous, active-high.
  - All outputs go to 0, FSM goes to IDLE, wait counter to 0, last_grant to 1 (port 0 wins the first tie).
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any request is high, grant one port: the only requester, or on a tie the port not in last_grant.
  - Latch the granted port's address, we, wdata and func_3; load the counter with WAIT_CYCLES.
  - Go to WAIT, or straight to RESP when WAIT_CYCLES = 0.
- WAIT: decrement the counter; when it reaches 1, go to RESP on the next edge.
- RESP:
  - Pulse the granted port's ack for exactly one cycle with rdata/err valid, and update last_grant.
  - Commit any store on the same edge that drives ack.
  - Return to IDLE.
- Latency: request granted in IDLE at cycle T; ack is high in cycle T+WAIT_CYCLES+1.
- Back-to-back requests: a request still high after its ack is re-arbitrated in the IDLE cycle after RESP, so the minimum spacing between acks is WAIT_CYCLES+2 cycles.
- Request changes: changes to a granted port's inputs after the grant are ignored (latched copy is used).
- Dropped requests: a request dropped before ack is still completed, and the ack pulse is emitted regardless.
- Address mapping: word index = addr[ADDR_WIDTH+1:2]; upper bits are ignored, so out-of-range addresses wrap modulo the RAM depth.
- Port 1 decode: always a word read; addr[1:0] is ignored; o_err_0 is not affected.
- Port 0 func_3 decode:
  - 000 LB/SB: byte lane addr[1:0].
  - 001 LH/SH: half lane addr[1].
  - 010 LW/SW: full word.
  - 100 LBU and 101 LHU: zero-extended loads; as stores (we=1) they are illegal.
- Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores: read-modify-write of the addressed word; only the selected byte lanes change.
- Error conditions:
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - func_3 of 011, 110 or 111.
  - Store with func_3 100 or 101.
- On error: the ack still pulses, o_err_0=1, o_rdata_0=0, and no RAM write occurs.
- Outputs outside ack: o_rdata_x and o_err_0 are 0 whenever the corresponding ack is low.
- Reset mid-transaction: the transaction is aborted and no ack is issued. A store is lost unless reset asserts after the RESP edge.

Test Plan:
- Word write then read (WAIT_CYCLES=2):
  - SW 0xDEADBEEF to 0x40 -> o_ack_0 is high 3 cycles after the grant cycle.
  - LW 0x40 -> o_rdata_0 = 0xDEADBEEF with o_err_0 = 0.
- Byte and half lanes:
  - Word 0x40 = 0x11223344; SB 0x80 to 0x41 -> LW gives 0x11228044.
  - LB 0x41 -> 0xFFFFFF80; LBU 0x41 -> 0x00000080; LH 0x42 -> 0x00001122.
- Misaligned and illegal accesses:
  - LW 0x42 -> ack with o_err_0 = 1, o_rdata_0 = 0.
  - SH 0x41 with data 0xFFFF -> err, and a following LW 0x40 is unchanged.
  - func_3 = 011 -> err.
- Simultaneous requests:
  - Both ports request from reset -> port 0 acked first, then port 1.
  - Both ports held high continuously -> acks alternate 0, 1, 0, 1, spaced WAIT_CYCLES+2 cycles apart.
- Wrap-around and WAIT_CYCLES=0:
  - Fetch 0x00001000 (ADDR_WIDTH=10) -> returns the word at 0x0.
  - With WAIT_CYCLES=0, ack is high in cycle T+1.
- Reset mid-operation:
  - Assert i_rst during WAIT of SW 0x55 to 0x80 -> no ack; all outputs 0 immediately.
  - After release, LW 0x80 -> the pre-store value.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - two-port round-robin RAM responder with wait states and RV32I sub-word decode
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_0,
    input  logic        i_we_0,
    input  logic [31:0] i_addr_0,
    input  logic [31:0] i_wdata_0,
    input  logic [2:0]  i_func_3_0,
    output logic        o_ack_0,
    output logic [31:0] o_rdata_0,
    output logic        o_err_0,
    input  logic        i_req_1,
    input  logic [31:0] i_addr_1,
    output logic        o_ack_1,
    output logic [31:0] o_rdata_1,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_t      state;
    logic [3:0]  cnt;
    logic        last_grant;
    logic        gnt;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_we;
    logic [2:0]  l_func_3;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    logic        any_req;
    logic        arb_sel;
    logic        cur_gnt;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic        cur_we;
    logic [2:0]  cur_func_3;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0] rd_word;
    logic [31:0] lane_shift;
    logic [15:0] half_sel;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic        p0_err;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        enter_resp;
    logic        do_store;
    logic        unused_addr_bits;

    assign any_req = i_req_0 | i_req_1;
    assign arb_sel = (i_req_0 && i_req_1) ? ~last_grant : i_req_1;

    // In IDLE the live arbitrated inputs are decoded so a zero-wait grant can respond on the next edge.
    always_comb begin
        cur_gnt    = gnt;
        cur_addr   = l_addr;
        cur_wdata  = l_wdata;
        cur_we     = l_we;
        cur_func_3 = l_func_3;
        if (state == S_IDLE) begin
            cur_gnt = arb_sel;
            if (arb_sel) begin
                cur_addr   = i_addr_1;
                cur_wdata  = 32'h0;
                cur_we     = 1'b0;
                cur_func_3 = 3'b010;
            end else begin
                cur_addr   = i_addr_0;
                cur_wdata  = i_wdata_0;
                cur_we     = i_we_0;
                cur_func_3 = i_func_3_0;
            end
        end
    end

    assign widx             = cur_addr[ADDR_WIDTH+1:2];
    assign rd_word          = mem[widx];
    assign lane_shift       = rd_word >> {cur_addr[1:0], 3'b000};
    assign half_sel         = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign unused_addr_bits = ^cur_addr[31:ADDR_WIDTH+2];

    always_comb begin
        p0_err  = 1'b0;
        ld_data = 32'h0;
        st_word = rd_word;
        case (cur_func_3)
            3'b000: begin
                ld_data = {{24{lane_shift[7]}}, lane_shift[7:0]};
                st_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
            end
            3'b001: begin
                p0_err  = cur_addr[0];
                ld_data = {{16{half_sel[15]}}, half_sel};
                st_word[{cur_addr[1], 4'b0000} +: 16] = cur_wdata[15:0];
            end
            3'b010: begin
                p0_err  = (cur_addr[1:0] != 2'b00);
                ld_data = rd_word;
                st_word = cur_wdata;
            end
            3'b100: begin
                p0_err  = cur_we;
                ld_data = {24'h0, lane_shift[7:0]};
            end
            3'b101: begin
                p0_err  = cur_we | cur_addr[0];
                ld_data = {16'h0, half_sel};
            end
            default: p0_err = 1'b1;
        endcase
    end

    always_comb begin
        resp_err   = 1'b0;
        resp_rdata = rd_word;
        if (!cur_gnt) begin
            resp_err   = p0_err;
            resp_rdata = (p0_err || cur_we) ? 32'h0 : ld_data;
        end
    end

    assign enter_resp = ((state == S_IDLE) && any_req && NO_WAIT) ||
                        ((state == S_WAIT) && (cnt == 4'd1));
    assign do_store   = enter_resp && !cur_gnt && cur_we && !p0_err && !i_rst;

    always_ff @(posedge i_clk) begin
        if (do_store)
            mem[widx] <= st_word;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            l_addr     <= 32'h0;
            l_wdata    <= 32'h0;
            l_we       <= 1'b0;
            l_func_3   <= 3'b000;
            o_ack_0    <= 1'b0;
            o_ack_1    <= 1'b0;
            o_rdata_0  <= 32'h0;
            o_rdata_1  <= 32'h0;
            o_err_0    <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_ack_0   <= 1'b0;
            o_ack_1   <= 1'b0;
            o_rdata_0 <= 32'h0;
            o_rdata_1 <= 32'h0;
            o_err_0   <= 1'b0;
            if (enter_resp) begin
                if (cur_gnt) begin
                    o_ack_1   <= 1'b1;
                    o_rdata_1 <= resp_rdata;
                end else begin
                    o_ack_0   <= 1'b1;
                    o_rdata_0 <= resp_rdata;
                    o_err_0   <= resp_err;
                end
            end
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt      <= arb_sel;
                        l_addr   <= cur_addr;
                        l_wdata  <= cur_wdata;
                        l_we     <= cur_we;
                        l_func_3 <= cur_func_3;
                        cnt      <= WAIT_INIT;
                        state    <= NO_WAIT ? S_RESP : S_WAIT;
                        o_busy   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1)
                        state <= S_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                S_RESP: begin
                    last_grant <= gnt;
                    state      <= S_IDLE;
                    o_busy     <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
